// File: rtl/dl_mem_arb_pkg.sv
// dl_mem_arb_pkg: shared types and widths for the download/core memory arbiter.
//   AddrW      - memory word-address width
//   DataW      - memory data width
//   state_e    - arbiter FSM states
//   dl_entry_t - one buffered download word (word address + data)
package dl_mem_arb_pkg;

  localparam int unsigned AddrW = 24;
  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDlWr,
    StCore,
    StWaitAck
  } state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } dl_entry_t;

endpackage

// File: rtl/dl_wfifo.sv
// dl_wfifo: synchronous FIFO buffering download words ahead of the memory port.
// Ports:
//   clk_sys, reset - clock and synchronous active-high reset
//   push, din      - write request and entry; ignored when full unless popping too
//   pop            - remove head entry; ignored when empty
//   dout           - current head entry (valid while !empty)
//   full, empty    - occupancy flags
module dl_wfifo
  import dl_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  dl_entry_t din,
  output dl_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  dl_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/dl_mem_arb.sv
// dl_mem_arb: arbitrates one memory port between SPI download writes (buffered in a
// FIFO, strict priority) and core read/write requests; reports download size/completion.
// Ports:
//   clk_sys, reset                 - clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout - download port; each ioctl_wr toggle = one word
//   core_req/we/addr/din           - core request (level, held until core_ack)
//   core_ack, core_dout            - completion pulse and read data (held)
//   mem_req/we/addr/din            - memory request (level, held until mem_ack)
//   mem_ack, mem_dout              - memory completion pulse and read data
//   rom_size, rom_ready            - byte size of last download, completion pulse
//   dl_overflow                    - sticky: a download word was dropped
module dl_mem_arb
  import dl_mem_arb_pkg::*;
#(
  parameter logic [7:0]  DL_INDEX   = 8'h00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [DataW-1:0] ioctl_dout,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [AddrW-1:0] core_addr,
  input  logic [DataW-1:0] core_din,
  output logic             core_ack,
  output logic [DataW-1:0] core_dout,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AddrW-1:0] mem_addr,
  output logic [DataW-1:0] mem_din,
  input  logic             mem_ack,
  input  logic [DataW-1:0] mem_dout,
  output logic [24:0]      rom_size,
  output logic             rom_ready,
  output logic             dl_overflow
);

  state_e      state_q;
  logic        wr_q, dl_q;
  logic        is_dl_q, armed_q;
  logic [24:0] max_end_q, max_end_d, word_end;
  logic        wr_edge, dl_rise, dl_fall;
  logic        push, pop, accept;
  logic        fifo_full, fifo_empty;
  dl_entry_t   fifo_din, fifo_head;
  logic        unused_bits;

  assign wr_edge  = ioctl_wr ^ wr_q;
  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign push     = wr_edge & ioctl_download & (ioctl_index == DL_INDEX);
  // Only a download access in WAIT_ACK retires the FIFO head.
  assign pop      = (state_q == StWaitAck) & mem_ack & is_dl_q;
  assign accept   = push & (~fifo_full | pop);
  assign fifo_din = {ioctl_addr[24:1], ioctl_dout};
  assign word_end = {1'b0, ioctl_addr[24:1]} + 25'd1;

  // Byte address bit 0 is meaningless for 16-bit words; the top word-end bit
  // would only matter for a full 32 MiB image, which rom_size cannot express.
  assign unused_bits = ioctl_addr[0] ^ max_end_q[24];

  dl_wfifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Highest word end seen in this download; a word accepted in the start cycle counts.
  always_comb begin
    max_end_d = dl_rise ? '0 : max_end_q;
    if (accept && (word_end > max_end_d)) begin
      max_end_d = word_end;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Load history from live inputs so no edge is seen right after reset.
      wr_q        <= ioctl_wr;
      dl_q        <= ioctl_download;
      max_end_q   <= '0;
      armed_q     <= 1'b0;
      rom_size    <= '0;
      rom_ready   <= 1'b0;
      dl_overflow <= 1'b0;
    end else begin
      wr_q      <= ioctl_wr;
      dl_q      <= ioctl_download;
      max_end_q <= max_end_d;
      rom_ready <= 1'b0;
      if (dl_rise) dl_overflow <= 1'b0;
      if (push && !accept) dl_overflow <= 1'b1;
      if (dl_rise) begin
        armed_q <= 1'b0;
      end else if (dl_fall) begin
        armed_q <= 1'b1;
      end else if (armed_q && fifo_empty && (state_q == StIdle)) begin
        armed_q   <= 1'b0;
        rom_ready <= 1'b1;
        rom_size  <= {max_end_q[23:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StIdle;
      is_dl_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      core_ack  <= 1'b0;
      core_dout <= '0;
    end else begin
      core_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // core_req is still high in the ack cycle; don't restart that access.
          if (!fifo_empty) begin
            state_q <= StDlWr;
          end else if (core_req && !core_ack) begin
            state_q <= StCore;
          end
        end
        StDlWr: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b1;
          mem_addr <= fifo_head.addr;
          mem_din  <= fifo_head.data;
          is_dl_q  <= 1'b1;
          state_q  <= StWaitAck;
        end
        StCore: begin
          mem_req  <= 1'b1;
          mem_we   <= core_we;
          mem_addr <= core_addr;
          mem_din  <= core_din;
          is_dl_q  <= 1'b0;
          state_q  <= StWaitAck;
        end
        StWaitAck: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!is_dl_q) begin
              core_ack <= 1'b1;
              if (!mem_we) core_dout <= mem_dout;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_mem_arb.sv
// tb_dl_mem_arb: directed bench for dl_mem_arb with a scoreboard of expected memory
// accesses and core read-data values, plus a simple acking memory model.
module tb_dl_mem_arb;
  import dl_mem_arb_pkg::*;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] din;
    logic [15:0] rdata;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [23:0] core_addr = '0;
  logic [15:0] core_din = '0;
  logic        core_ack;
  logic [15:0] core_dout;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dout = '0;
  logic [24:0] rom_size;
  logic        rom_ready;
  logic        dl_overflow;

  mem_exp_t    mem_q[$];
  logic [15:0] core_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rom_cnt = 0;
  int          core_acks = 0;
  int          wait_cnt = 0;
  int          lat = 1;
  int          acks_before;
  logic        ack_en = 1'b1;
  logic [24:0] rom_seen = '1;
  logic [15:0] exp_hold = '0;

  dl_mem_arb u_dut (
    .clk_sys       (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_din      (core_din),
    .core_ack      (core_ack),
    .core_dout     (core_dout),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_ack       (mem_ack),
    .mem_dout      (mem_dout),
    .rom_size      (rom_size),
    .rom_ready     (rom_ready),
    .dl_overflow   (dl_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; sample 1ns after the edge, then act as core and memory.
  task automatic tick();
    mem_exp_t e;
    @(posedge clk);
    #1;
    if (core_ack) begin
      core_acks++;
      if (core_q.size() == 0) check("core_spurious", core_ack, 1'b0);
      else check("core_dout", core_dout, core_q.pop_front());
      core_req = 1'b0;
    end
    if (rom_ready) begin
      rom_cnt++;
      rom_seen = rom_size;
    end
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && ack_en) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        wait_cnt = 0;
        if (mem_q.size() == 0) begin
          check("mem_spurious", mem_req, 1'b0);
          mem_dout = '0;
        end else begin
          e = mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_din", mem_din, e.din);
          mem_dout = e.rdata;
        end
        mem_ack = 1'b1;
      end
    end
  endtask

  task automatic toggle(input logic [24:0] addr, input logic [15:0] data, input logic acc);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = ~ioctl_wr;
    if (acc) mem_q.push_back({1'b1, addr[24:1], data, 16'h0000});
    tick();
  endtask

  task automatic dl_start();
    rom_cnt  = 0;
    rom_seen = '1;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic core_access(input logic we, input logic [23:0] addr, input logic [15:0] din,
                             input logic [15:0] rdata);
    core_we   = we;
    core_addr = addr;
    core_din  = din;
    core_req  = 1'b1;
    mem_q.push_back({we, addr, din, rdata});
    if (!we) exp_hold = rdata;
    core_q.push_back(exp_hold);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((mem_q.size() != 0 || core_q.size() != 0 || mem_req) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, n < 200, 1'b1);
  endtask

  task automatic expect_rom(input string tag, input logic [24:0] exp_size);
    for (int i = 0; i < 40; i++) tick();
    check({tag, "_rom_pulses"}, rom_cnt, 1);
    check({tag, "_rom_size_at_pulse"}, rom_seen, exp_size);
    check({tag, "_rom_size"}, rom_size, exp_size);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_flags", {mem_req, mem_we, core_ack, rom_ready, dl_overflow}, 5'b0);
    check("rst_core_dout", core_dout, 16'h0000);
    check("rst_rom_size", rom_size, 25'h0);
    check("rst_state", u_dut.state_q, StIdle);

    // Basic download of four words, drained through the memory port
    lat = 2;
    ack_en = 1'b1;
    dl_start();
    toggle(25'h0, 16'h1111, 1'b1);
    toggle(25'h2, 16'h2222, 1'b1);
    toggle(25'h4, 16'h3333, 1'b1);
    toggle(25'h6, 16'h4444, 1'b1);
    dl_end();
    expect_rom("t1", 25'd8);
    check("t1_no_overflow", dl_overflow, 1'b0);
    check("t1_all_writes", mem_q.size(), 0);

    // Overflow: memory stalled, fifth word dropped
    lat = 1;
    ack_en = 1'b0;
    dl_start();
    toggle(25'h10, 16'hA001, 1'b1);
    toggle(25'h12, 16'hA002, 1'b1);
    toggle(25'h14, 16'hA003, 1'b1);
    toggle(25'h16, 16'hA004, 1'b1);
    check("t2_no_overflow_yet", dl_overflow, 1'b0);
    toggle(25'h18, 16'hA005, 1'b0);
    check("t2_overflow_set", dl_overflow, 1'b1);
    ack_en = 1'b1;
    dl_end();
    expect_rom("t2", 25'h18);
    check("t2_overflow_sticky", dl_overflow, 1'b1);
    dl_start();
    check("t2_overflow_cleared", dl_overflow, 1'b0);
    dl_end();
    expect_rom("t2_empty", 25'h0);

    // Core read waits behind two buffered download words
    ack_en = 1'b0;
    dl_start();
    toggle(25'h20, 16'hA1A1, 1'b1);
    toggle(25'h22, 16'hB2B2, 1'b1);
    core_access(1'b0, 24'h000100, 16'h0000, 16'hBEEF);
    for (int i = 0; i < 3; i++) tick();
    check("t3_write_first", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 24'h000010});
    ack_en = 1'b1;
    wait_drain("t3");
    check("t3_core_dout_held", core_dout, 16'hBEEF);
    dl_end();
    expect_rom("t3", 25'h24);

    // Foreign index: nothing written, still completes with size 0
    ioctl_index = 8'h01;
    dl_start();
    toggle(25'h30, 16'h5555, 1'b0);
    toggle(25'h32, 16'h6666, 1'b0);
    toggle(25'h34, 16'h7777, 1'b0);
    check("t4_no_mem_req", mem_req, 1'b0);
    dl_end();
    expect_rom("t4", 25'h0);
    ioctl_index = 8'h00;

    // Toggles outside a download ignored; core write proceeds
    rom_cnt = 0;
    toggle(25'h40, 16'h9999, 1'b0);
    toggle(25'h42, 16'h8888, 1'b0);
    tick();
    check("t5_no_mem_req", mem_req, 1'b0);
    acks_before = core_acks;
    core_access(1'b1, 24'h000005, 16'h1234, 16'h0000);
    wait_drain("t5");
    check("t5_core_acked", core_acks, acks_before + 1);
    check("t5_no_rom_ready", rom_cnt, 0);

    // Reset during WAIT_ACK, late mem_ack ignored; edges during reset not seen
    ack_en = 1'b0;
    core_access(1'b0, 24'h000007, 16'h0000, 16'hCAFE);
    for (int i = 0; i < 4; i++) tick();
    check("t6_in_wait", {mem_req, u_dut.state_q}, {1'b1, StWaitAck});
    reset = 1'b1;
    ioctl_download = 1'b1;
    ioctl_wr = ~ioctl_wr;
    tick();
    reset = 1'b0;
    core_req = 1'b0;
    mem_q.delete();
    core_q.delete();
    wait_cnt = 0;
    acks_before = core_acks;
    tick();
    mem_ack = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_no_core_ack", core_acks, acks_before);
    check("t6_state", u_dut.state_q, StIdle);
    check("t6_no_overflow", dl_overflow, 1'b0);
    ack_en = 1'b1;
    rom_cnt = 0;
    dl_end();
    expect_rom("t6", 25'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
